// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package serial_sub_pkg;

    // Controller state: IDLE waits for start, BUSY shifts one bit per edge,
    // DONE is the single result-valid cycle that may chain straight into BUSY.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operation request / result bundle between a controller and the serial subtractor.
// Latency: n/a (wires only).
// Backpressure: start is only honoured while the subtractor is not busy.
//
// Signals:
//   start, a, b, b_in           controller -> subtractor (request and operands)
//   busy, done, diff, b_out     subtractor -> controller (status and held result)
//   diff_bit, diff_bit_valid    subtractor -> controller (serial result stream, LSB first)
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             diff_bit;
    logic             diff_bit_valid;

    modport master (
        output start, a, b, b_in,
        input  busy, done, diff, b_out, diff_bit, diff_bit_valid
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff, b_out, diff_bit, diff_bit_valid
    );
endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_a, i_b, i_bin  minuend bit, subtrahend bit, borrow in
//   o_d, o_bout      difference bit, borrow out
module serial_sub_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    assign o_d    = i_a ^ i_b ^ i_bin;
    // Borrow when b exceeds a outright, or when they tie and a borrow is pending.
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in mod 2^WIDTH, one bit per clock, LSB first.
// Latency: WIDTH edges after the start-accept edge; done pulses for one cycle.
// Backpressure: start ignored while busy; start in the done cycle chains the next op.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; aborts any operation in flight
//   bus    serial_subtractor_if slave: start/a/b/b_in in, busy/done/diff/b_out/diff_bit(_valid) out
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_subtractor_if.slave   bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_count;
    logic             r_br;
    logic             r_busy;
    logic             r_done;
    logic             r_b_out;
    logic             r_diff_bit;
    logic             r_diff_bit_valid;

    logic             w_d;
    logic             w_bout;
    logic             w_accept;
    logic [WIDTH-1:0] w_res_next;

    serial_sub_cell u_cell (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_bin  (r_br),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    // Written as shift/or so it stays legal when WIDTH is 1.
    assign w_res_next = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

    // A start is only taken when no operation is in flight.
    assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_a_sh           <= '0;
            r_b_sh           <= '0;
            r_res            <= '0;
            r_diff           <= '0;
            r_count          <= '0;
            r_br             <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_b_out          <= 1'b0;
            r_diff_bit       <= 1'b0;
            r_diff_bit_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_BUSY: begin
                    r_a_sh           <= r_a_sh >> 1;
                    r_b_sh           <= r_b_sh >> 1;
                    r_res            <= w_res_next;
                    r_br             <= w_bout;
                    r_count          <= r_count + 1'b1;
                    r_diff_bit       <= w_d;
                    r_diff_bit_valid <= 1'b1;
                    if (r_count == LAST) begin
                        // Only this edge updates the held result.
                        r_diff  <= w_res_next;
                        r_b_out <= w_bout;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done           <= 1'b0;
                    r_diff_bit_valid <= 1'b0;
                    if (!bus.start) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Load overrides the DONE/IDLE handling above, giving back-to-back issue.
            if (w_accept) begin
                r_a_sh  <= bus.a;
                r_b_sh  <= bus.b;
                r_br    <= bus.b_in;
                r_res   <= '0;
                r_count <= '0;
                r_busy  <= 1'b1;
                r_state <= ST_BUSY;
            end
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.diff           = r_diff;
    assign bus.b_out          = r_b_out;
    assign bus.diff_bit       = r_diff_bit;
    assign bus.diff_bit_valid = r_diff_bit_valid;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer subtraction.
    function automatic logic [7:0] ref_diff(input int a, input int b, input int bin);
        int r;
        r = a - b - bin;
        return r[7:0];
    endfunction

    function automatic logic ref_bout(input int a, input int b, input int bin);
        return (a < (b + bin));
    endfunction

    // Issues one op and gathers observations; callers do the comparisons.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output logic [7:0] bits, output int busy_n, output int lat,
                          output bit to, output logic [7:0] diff0, output bit held);
        int k;
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.b_in = bin;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 8'($urandom); bus.b = 8'($urandom); bus.b_in = 1'($urandom);
        diff0 = bus.diff; held = 1'b1; bits = '0; busy_n = 0; lat = 0; to = 1'b1; k = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            if (bus.diff_bit_valid && k < W) begin bits[k] = bus.diff_bit; k++; end
            if (bus.done) begin to = 1'b0; lat = c + 1; break; end
            if (bus.diff !== diff0) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.done, bus.diff, bus.b_out, bus.diff_bit, bus.diff_bit_valid} !== 13'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: busy=%b done=%b diff=%h b_out=%b bit=%b vld=%b, want all 0",
                         i, bus.busy, bus.done, bus.diff, bus.b_out, bus.diff_bit, bus.diff_bit_valid);
            end
            bus.start = 1'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom); bus.b_in = 1'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b done=%b, want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_basic();
        logic [7:0] bits, d0;
        int busy_n, lat;
        bit to, held;
        run_op(8'h5A, 8'h23, 1'b0, bits, busy_n, lat, to, d0, held);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: no done within bound"); end
        checks++;
        if (busy_n !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", busy_n); end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
        checks++;
        if (bits !== 8'h37) begin errors++; $display("FAIL basic_serial_bits: got %b want 00110111", bits); end
        checks++;
        if (bus.diff !== ref_diff(8'h5A, 8'h23, 0) || bus.b_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: diff=%h b_out=%b want 37 0", bus.diff, bus.b_out);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.diff_bit_valid !== 1'b0 || bus.busy !== 1'b0 || bus.diff !== 8'h37) begin
            errors++;
            $display("FAIL basic_after_done: done=%b vld=%b busy=%b diff=%h want 0 0 0 37",
                     bus.done, bus.diff_bit_valid, bus.busy, bus.diff);
        end
    endtask

    task automatic test_borrow();
        logic [7:0] bits, d0;
        int busy_n, lat;
        bit to, held;
        run_op(8'h00, 8'h01, 1'b0, bits, busy_n, lat, to, d0, held);
        checks++;
        if (to || bus.diff !== 8'hFF || bus.b_out !== ref_bout(0, 1, 0)) begin
            errors++;
            $display("FAIL borrow_0_minus_1: to=%b diff=%h b_out=%b want ff 1", to, bus.diff, bus.b_out);
        end
        run_op(8'h10, 8'h10, 1'b1, bits, busy_n, lat, to, d0, held);
        checks++;
        if (to || bus.diff !== ref_diff(16, 16, 1) || bus.b_out !== 1'b1) begin
            errors++;
            $display("FAIL borrow_with_bin: to=%b diff=%h b_out=%b want ff 1", to, bus.diff, bus.b_out);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, n;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h01; bus.b_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 8'hFF; bus.b = 8'h01;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 1'b0; n = 0;
        while (!seen && n < 20) begin
            if (bus.done) seen = 1'b1; else begin @(negedge clk); n++; end
        end
        t1 = cyc;
        checks++;
        if (!seen || bus.diff !== 8'h7F || bus.b_out !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_in_busy: seen=%b diff=%h b_out=%b want 7f 0", seen, bus.diff, bus.b_out);
        end
        // Start presented in the done cycle.
        bus.start = 1'b1; bus.a = 8'h33; bus.b = 8'h11; bus.b_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.diff !== 8'h7F) begin
            errors++;
            $display("FAIL b2b_launch: busy=%b diff=%h want 1 7f", bus.busy, bus.diff);
        end
        seen = 1'b0; n = 0;
        while (!seen && n < 20) begin
            if (bus.done) seen = 1'b1; else begin @(negedge clk); n++; end
        end
        t2 = cyc;
        checks++;
        if (!seen || (t2 - t1) !== 9) begin
            errors++;
            $display("FAIL b2b_spacing: seen=%b spacing=%0d want 9", seen, t2 - t1);
        end
        checks++;
        if (bus.diff !== ref_diff(8'h33, 8'h11, 0) || bus.b_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: diff=%h b_out=%b want 22 0", bus.diff, bus.b_out);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] bits, d0;
        int busy_n, lat;
        bit to, held, saw_done;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.b_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 8'h00 || bus.diff_bit_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear: busy=%b done=%b diff=%h vld=%b want 0 0 00 0",
                     bus.busy, bus.done, bus.diff, bus.diff_bit_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL abort_no_done: activity seen after abort, want none"); end
        run_op(8'hAA, 8'h55, 1'b0, bits, busy_n, lat, to, d0, held);
        checks++;
        if (to || bus.diff !== 8'h55 || bus.b_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_then_op: to=%b diff=%h b_out=%b want 55 0", to, bus.diff, bus.b_out);
        end
    endtask

    task automatic test_random();
        logic [7:0] bits, d0, a, b, prev, exp_d;
        logic bin, exp_b;
        int busy_n, lat;
        bit to, held;
        prev = bus.diff === 8'h55 ? 8'h55 : 8'h55;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            exp_d = ref_diff(a, b, bin);
            exp_b = ref_bout(a, b, bin);
            run_op(a, b, bin, bits, busy_n, lat, to, d0, held);
            checks++;
            if (to || lat !== 8) begin
                errors++;
                $display("FAIL rand_latency op %0d: to=%b lat=%0d want 8", i, to, lat);
            end
            checks++;
            if (d0 !== prev || !held) begin
                errors++;
                $display("FAIL rand_hold op %0d: diff at start=%h held=%b want %h 1", i, d0, held, prev);
            end
            checks++;
            if (bus.diff !== exp_d || bus.b_out !== exp_b) begin
                errors++;
                $display("FAIL rand_result op %0d: %h-%h-%b diff=%h b_out=%b want %h %b",
                         i, a, b, bin, bus.diff, bus.b_out, exp_d, exp_b);
            end
            checks++;
            if (bits !== exp_d) begin
                errors++;
                $display("FAIL rand_serial op %0d: bits=%h want %h", i, bits, exp_d);
            end
            prev = exp_d;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing diff = a - b - b_in, LSB first, one bit per clock through a registered borrow flop. It is the inverse operation of our registered full-adder cell, so datapath checks can round-trip add/subtract results. A start/busy/done handshake lets a controller issue operations. Results and borrow-out are registered and held until the next operation completes.

Parameters:
WIDTH, 8, operand/result width in bits; must be at least 1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
b_in  input  1  initial borrow; captured on accepted start
busy  output  1  high while state is BUSY
done  output  1  one-cycle pulse; diff/b_out valid
diff  output  WIDTH  registered result, a - b - b_in mod 2^WIDTH
b_out  output  1  final borrow; 1 when a < b + b_in
diff_bit  output  1  serial result bit, LSB first
diff_bit_valid  output  1  high for the cycle after each bit is produced

Behaviour:
- Reset (reset=0, async):
  - state goes to IDLE.
  - busy, done, diff, b_out, diff_bit and diff_bit_valid all go to 0.
  - Internal shift registers, counter and borrow flop clear.
- Reset asserted mid-operation aborts the operation: no done pulse, and the partial result is discarded.
- FSM states:
  - IDLE: start=1 loads a, b and b_in into the shift/borrow registers, clears count, goes to BUSY. start=0 stays in IDLE.
  - BUSY: each edge processes bit i = count, using a_sh[0] (a0), b_sh[0] (b0) and br (borrow flop):
    - d = a0 ^ b0 ^ br
    - br <= (~a0 & b0) | (~(a0 ^ b0) & br)
    - d shifts into the MSB of the result shift register; a_sh and b_sh shift right.
    - count increments.
    - diff_bit <= d; diff_bit_valid <= 1.
    - When count == WIDTH-1 on this edge: diff <= the final shifted result, b_out <= the new br, done <= 1, state goes to DONE.
    - start is ignored in BUSY.
  - DONE (exactly one cycle):
    - done drops on the next edge and diff_bit_valid <= 0.
    - start=1 loads a new operation and goes directly to BUSY (back-to-back).
    - Otherwise goes to IDLE.
- Timing:
  - The start-accept edge is E0; bits are processed on edges E1..E_WIDTH.
  - done is high between E_WIDTH and E_WIDTH+1.
  - Throughput is one operation per WIDTH+1 cycles.
- Outputs:
  - busy is registered and high exactly while the state is BUSY.
  - diff and b_out change only on the completion edge; otherwise they hold, including across new starts.
- Widths:
  - count is $clog2(WIDTH+1) bits.
  - Arithmetic is modulo 2^WIDTH; there is no sign interpretation.
- WIDTH=1: BUSY lasts one edge; done follows E1.

Decomposition:
- Package serial_sub_pkg holds the state enum (ST_IDLE, ST_BUSY, ST_DONE).
- Sub-module serial_sub_cell: combinational 1-bit full subtractor (a, b, bin -> d, bout), instanced once. The borrow flop lives in the parent.

Test Plan:
1. Hold reset=0 with random inputs and start pulses -> all outputs 0, busy never rises. Releasing reset leaves the block in IDLE.
2. WIDTH=8, a=0x5A, b=0x23, b_in=0, start for one cycle:
   - busy high for 8 cycles.
   - diff_bit sequence 1,1,1,0,1,1,0,0.
   - done on E8 with diff=0x37, b_out=0.
3. a=0x00, b=0x01, b_in=0 -> diff=0xFF, b_out=1. Also a=0x10, b=0x10, b_in=1 -> diff=0xFF, b_out=1.
4. Start pulses during BUSY (a=0xFF, b=0x01 pending op 0x80-0x01):
   - Mid-operation pulses are ignored; result diff=0x7F, b_out=0.
   - start held in the DONE cycle launches the next op immediately; done pulses 9 cycles apart.
5. Pulse reset low after bit 4 of a=0xAA-0x55 -> busy/done/diff clear immediately, no done pulse. A following op 0xAA-0x55 yields diff=0x55, b_out=0.
6. Random regression of 1000 ops -> diff and b_out match (a - b - b_in) mod 256 and its borrow, and diff holds between operations.
